// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder : word-organised data memory with byte-lane stores,
//                  extending loads, wait states and error reporting. Rev 1.0
// ============================================================================
`default_nettype none

module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          IDXW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] c_depth    = 32'(DEPTH_WORDS);
  localparam logic [3:0]  c_lat_m1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic        c_lat_zero = (LATENCY == 0);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t r_state, w_next;

  logic [31:0]     r_mem [DEPTH_WORDS];
  logic [3:0]      r_cnt;
  logic            r_we;
  logic [IDXW-1:0] r_idx;
  logic [1:0]      r_lane;
  logic [31:0]     r_wdata;
  logic [1:0]      r_size;
  logic            r_uns;

  logic            w_accept;
  logic            w_err;
  logic            w_access;
  logic            w_wr_en;
  logic            w_a_we;
  logic [IDXW-1:0] w_a_idx;
  logic [1:0]      w_a_lane;
  logic [31:0]     w_a_wdata;
  logic [1:0]      w_a_size;
  logic            w_a_uns;
  logic [3:0]      w_be;
  logic [31:0]     w_wd;
  logic [31:0]     w_rword;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [31:0]     w_ldata;

  assign req_ready = (r_state == S_IDLE) && !rst;
  assign rsp_valid = (r_state == S_RESP);
  assign w_accept  = req_valid && req_ready;

  // Range check covers every size: the word index must land inside storage.
  assign w_err = (req_size == 2'b11)
              || ((req_size == 2'b01) && req_addr[0])
              || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
              || ({2'b00, req_addr[31:2]} >= c_depth);

  // Zero-latency accesses use the live request; otherwise the captured copy.
  assign w_a_we    = (r_state == S_IDLE) ? req_we                  : r_we;
  assign w_a_idx   = (r_state == S_IDLE) ? req_addr[IDXW+1:2]      : r_idx;
  assign w_a_lane  = (r_state == S_IDLE) ? req_addr[1:0]           : r_lane;
  assign w_a_wdata = (r_state == S_IDLE) ? req_wdata               : r_wdata;
  assign w_a_size  = (r_state == S_IDLE) ? req_size                : r_size;
  assign w_a_uns   = (r_state == S_IDLE) ? req_unsigned            : r_uns;

  assign w_access = ((r_state == S_IDLE) && w_accept && !w_err && c_lat_zero)
                 || ((r_state == S_BUSY) && (r_cnt == 4'd0));
  assign w_wr_en  = w_access && w_a_we && !rst;

  always_comb begin
    w_be = 4'b0000;
    w_wd = w_a_wdata;
    case (w_a_size)
      2'b00: begin
        w_be = 4'b0001 << w_a_lane;
        w_wd = {4{w_a_wdata[7:0]}};
      end
      2'b01: begin
        w_be = w_a_lane[1] ? 4'b1100 : 4'b0011;
        w_wd = {2{w_a_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
  end

  assign w_rword = r_mem[w_a_idx];
  assign w_byte  = w_rword[{w_a_lane, 3'b000} +: 8];
  assign w_half  = w_a_lane[1] ? w_rword[31:16] : w_rword[15:0];

  always_comb begin
    w_ldata = w_rword;
    case (w_a_size)
      2'b00:   w_ldata = w_a_uns ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_ldata = w_a_uns ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_ldata = w_rword;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_a_idx][8*b +: 8] <= w_wd[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_err || c_lat_zero) ? S_RESP : S_BUSY;
      S_BUSY: if (r_cnt == 4'd0) w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 4'd0;
      r_we      <= 1'b0;
      r_idx     <= '0;
      r_lane    <= 2'd0;
      r_wdata   <= 32'd0;
      r_size    <= 2'd0;
      r_uns     <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && w_accept) begin
        r_we    <= req_we;
        r_idx   <= req_addr[IDXW+1:2];
        r_lane  <= req_addr[1:0];
        r_wdata <= req_wdata;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        if (w_err) begin
          rsp_err   <= 1'b1;
          rsp_rdata <= 32'd0;
        end else begin
          r_cnt <= c_lat_m1;
        end
      end
      if ((r_state == S_BUSY) && (r_cnt != 4'd0)) r_cnt <= r_cnt - 4'd1;
      if (w_access) begin
        rsp_err   <= 1'b0;
        rsp_rdata <= w_a_we ? 32'd0 : w_ldata;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder : scoreboard bench for dmem_responder (LATENCY 2 and 0).
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;

  logic        v0, rdy0, we0, un0, rv0, rr0, er0;
  logic [31:0] addr0, wd0, rd0;
  logic [1:0]  sz0;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] sb[$];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst),
    .req_valid(v0), .req_ready(rdy0), .req_we(we0),
    .req_addr(addr0), .req_wdata(wd0), .req_size(sz0),
    .req_unsigned(un0),
    .rsp_valid(rv0), .rsp_ready(rr0), .rsp_rdata(rd0),
    .rsp_err(er0)
  );

  // Monitor: every completed handshake is checked against the queue head.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      logic [32:0] exp;
      n_cmp++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL rsp_unexpected: got err=%0b rdata=%08h, none expected", rsp_err, rsp_rdata);
      end else begin
        exp = sb.pop_front();
        if ({rsp_err, rsp_rdata} !== exp) begin
          n_bad++;
          $display("FAIL rsp_data: got err=%0b rdata=%08h, expected err=%0b rdata=%08h",
                   rsp_err, rsp_rdata, exp[32], exp[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, expected %08h", name, act, exp);
    end
  endtask

  // Issues one request, queues its expected response and checks the number
  // of cycles from acceptance to the first cycle rsp_valid is seen high.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] exp_d, input logic exp_e,
                        input int exp_lat, input string name);
    int n;
    req_we = we; req_addr = addr; req_wdata = wd; req_size = sz; req_unsigned = uns;
    req_valid = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    if (!req_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL %s_accept: req_ready stayed low", name);
      req_valid = 1'b0;
      return;
    end
    sb.push_back({exp_e, exp_d});
    @(posedge clk); #1 req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    chk({name, "_lat"}, n, exp_lat);
    if (rsp_ready) @(posedge clk);
    #1;
  endtask

  task automatic lat0_req(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [1:0] sz, input logic uns,
                          input logic [31:0] exp_d, input string name);
    we0 = we; addr0 = addr; wd0 = wd; sz0 = sz; un0 = uns; v0 = 1'b1;
    @(negedge clk);
    chk({name, "_ready"}, {31'd0, rdy0}, 32'd1);
    @(posedge clk); #1 v0 = 1'b0;
    @(negedge clk);
    chk({name, "_valid"}, {31'd0, rv0}, 32'd1);
    chk({name, "_rdata"}, rd0, exp_d);
    chk({name, "_err"}, {31'd0, er0}, 32'd0);
    @(posedge clk); #1;
  endtask

  localparam logic [1:0] B = 2'b00, H = 2'b01, W = 2'b10, X = 2'b11;

  initial begin
    rst = 1'b1; rsp_ready = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    req_size = W; req_unsigned = 1'b0;
    v0 = 1'b0; we0 = 1'b0; addr0 = 32'd0; wd0 = 32'd0; sz0 = W; un0 = 1'b0; rr0 = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   {31'd0, rsp_err}, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1;

    // Word store/load, byte store, extending loads
    do_req(1, 32'h10, 32'hDEADBEEF, W, 0, 32'h0,        0, 3, "st_w10");
    do_req(0, 32'h10, 32'h0,        W, 0, 32'hDEADBEEF, 0, 3, "ld_w10");
    do_req(1, 32'h13, 32'h00000080, B, 0, 32'h0,        0, 3, "st_b13");
    do_req(0, 32'h13, 32'h0,        B, 0, 32'hFFFFFF80, 0, 3, "ld_bs13");
    do_req(0, 32'h13, 32'h0,        B, 1, 32'h00000080, 0, 3, "ld_bu13");
    do_req(0, 32'h10, 32'h0,        W, 0, 32'h80ADBEEF, 0, 3, "ld_w10b");
    do_req(0, 32'h12, 32'h0,        H, 1, 32'h000080AD, 0, 3, "ld_hu12");

    // Error cases respond one cycle after acceptance, memory untouched
    do_req(0, 32'h11, 32'h0,        H, 0, 32'h0,        1, 1, "err_h11");
    do_req(1, 32'h12, 32'h11111111, W, 0, 32'h0,        1, 1, "err_w12");
    do_req(0, 32'h10, 32'h0,        X, 0, 32'h0,        1, 1, "err_sz11");
    do_req(0, 32'h10, 32'h0,        W, 0, 32'h80ADBEEF, 0, 3, "ld_w10c");

    // Range boundary
    do_req(0, 32'h400, 32'h0,        W, 0, 32'h0,        1, 1, "err_w400");
    do_req(1, 32'h3FC, 32'hCAFEF00D, W, 0, 32'h0,        0, 3, "st_w3fc");
    do_req(0, 32'h3FC, 32'h0,        W, 0, 32'hCAFEF00D, 0, 3, "ld_w3fc");
    do_req(0, 32'h3FE, 32'h0,        H, 0, 32'hFFFFCAFE, 0, 3, "ld_hs3fe");
    do_req(0, 32'h3FC, 32'h0,        B, 1, 32'h0000000D, 0, 3, "ld_bu3fc");

    // Backpressure with a competing request held on the input
    rsp_ready = 1'b0;
    do_req(0, 32'h10, 32'h0, W, 0, 32'h80ADBEEF, 0, 3, "ld_bp");
    req_we = 1'b1; req_addr = 32'h10; req_wdata = 32'h0; req_size = W; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_rdata", rsp_rdata, 32'h80ADBEEF);
      chk("bp_err",   {31'd0, rsp_err}, 32'd0);
      chk("bp_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk); #1 req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    do_req(0, 32'h10, 32'h0, W, 0, 32'h80ADBEEF, 0, 3, "ld_after_bp");

    // Reset while a store is waiting in BUSY
    do_req(1, 32'h20, 32'hDEADBEEF, W, 0, 32'h0, 0, 3, "st_w20");
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_size = W; req_valid = 1'b1;
    @(negedge clk);
    chk("busy_rst_accept", {31'd0, req_ready}, 32'd1);
    @(posedge clk); #1 req_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("busy_rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("busy_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    chk("busy_rst_valid2", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk); #1;
    do_req(0, 32'h20, 32'h0, W, 0, 32'hDEADBEEF, 0, 3, "ld_w20");

    // Zero-latency instance
    lat0_req(1, 32'h8, 32'h55AA00FF, W, 0, 32'h0,        "l0_st_w8");
    lat0_req(0, 32'h8, 32'h0,        W, 0, 32'h55AA00FF, "l0_ld_w8");
    lat0_req(0, 32'hA, 32'h0,        B, 0, 32'hFFFFFFAA, "l0_ld_bsA");

    repeat (3) @(posedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core: serves load/store requests issued by the memory stage over a valid/ready request channel and returns results on a valid/ready response channel. It holds word-organised storage with byte-lane stores, sign/zero-extending loads, a programmable wait-state latency and alignment/range error reporting. It sits between the memory-stage initiator and the writeback path, with one transaction outstanding at a time.

## Interface
- DEPTH_WORDS, 256, number of 32-bit words of storage (power of two not required)
- LATENCY, 2, wait cycles between acceptance and access (0..15)
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-aligned
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- rsp_valid  out  1  response present
- rsp_ready  in  1  initiator takes response
- rsp_rdata  out  32  load result; 0 for stores and errors
- rsp_err  out  1  request rejected (misaligned, illegal size, out of range)

## Operation
- States: IDLE, BUSY, RESP. req_ready = (state==IDLE) && !rst. rsp_valid = (state==RESP).
- IDLE: on req_valid && req_ready, capture we/addr/wdata/size/unsigned.
  - Error check at capture: size==11; half with addr[0]=1; word with addr[1:0]!=00; word index addr[31:2] >= DEPTH_WORDS. Error -> RESP directly, rsp_err=1, rsp_rdata=0, no memory change, LATENCY not applied.
  - Legal, LATENCY=0 -> access on the capture edge, go RESP.
  - Legal, LATENCY>0 -> BUSY, wait counter loaded LATENCY-1.
- BUSY: counter decrements each edge; on the edge where counter==0, perform access and go RESP. req_valid ignored.
- Access, store: byte writes lane addr[1:0] with wdata[7:0]; half writes lanes {addr[1],0},{addr[1],1} with wdata[15:0]; word writes all lanes. Untouched lanes keep value. rsp_rdata=0, rsp_err=0.
- Access, load: read word, select byte (lane addr[1:0]) or half (addr[1]), extend to 32 bits per req_unsigned; word returned as-is. Result registered into rsp_rdata.
- RESP: rsp_valid, rsp_rdata, rsp_err held stable until rsp_valid && rsp_ready; that edge returns to IDLE. No new request accepted on that same edge.
- Storage contents are not cleared by reset; contents are undefined until written.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_rdata 0, rsp_err 0, counter 0, req_ready 0 while rst high, 1 the cycle after rst falls.
- Legal request accepted at edge E0: access at edge E0+LATENCY; rsp_valid first high in the cycle after E0+LATENCY.
- Error request accepted at E0: rsp_valid high in the cycle after E0.
- Minimum request-to-request spacing with rsp_ready tied high: LATENCY+2 cycles.
- rst asserted in BUSY: pending store is dropped (memory unchanged), pending load discarded, state IDLE next cycle. rst asserted in RESP: response dropped without handshake.
- rsp_ready asserted outside RESP has no effect.

## Test plan
- LATENCY=2: reset, store word 0xDEADBEEF at 0x10, then load word 0x10 -> each rsp_valid rises 3 cycles after acceptance; load returns 0xDEADBEEF, rsp_err=0; store response rdata=0.
- Store byte 0x80 at 0x13, then loads at 0x13: signed byte -> 0xFFFFFF80, unsigned byte -> 0x00000080, word at 0x10 -> 0x80ADBEEF; half unsigned at 0x12 -> 0x000080AD.
- Half load at 0x11, word store at 0x12, size=11 at 0x10 -> each rsp_err=1, rsp_rdata=0, response one cycle after acceptance, word 0x10 unchanged.
- DEPTH_WORDS=256: word load at 0x400 -> rsp_err=1; word store at 0x3FC -> rsp_err=0 and readable back.
- Backpressure: hold rsp_ready low 5 cycles in RESP with req_valid high -> rsp_valid/rsp_rdata/rsp_err stable, req_ready 0, no second request accepted; release -> IDLE next cycle.
- Reset mid-BUSY of word store 0x12345678 to 0x20 (previously 0xDEADBEEF) -> after reset, load 0x20 returns 0xDEADBEEF; rsp_valid 0 and req_ready 1 after reset. LATENCY=0 variant: load response in cycle after acceptance.
